uart_tx_arb_2_a_1: RTL and testbench

- Merges two independent byte producers onto the single UART transmit path: CPU store path and DMA/peripheral path.
- Uses a valid/ready handshake on every channel, round-robin arbitration on collision, and a one-entry registered output stage.
- Sits in the UART peripheral between the producers and the TX shifter. It is the converging counterpart of the 2-output routing demux on the receive/write side.
- Every output byte carries a source tag so status logic can attribute completions.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/rr_arb_2.sv | 35 +++
 rtl/uart_tx_arb_2_a_1.sv | 97 +++++++++
 tb/tb_uart_tx_arb_2_a_1.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART transmit merge path.
//               Provides the default byte width, the source tag type and the
//               output-register state type.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default byte width of every data channel
    localparam int unsigned DATA_W_DEF = 8;

    // Source tag carried with each output byte
    typedef enum logic {SRC_0, SRC_1} uart_src_e;

    // Output register occupancy
    typedef enum logic {ST_EMPTY, ST_FULL} arb_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/rr_arb_2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_2
// Description : Two-requester round-robin grant logic, purely combinational.
//               A lone requester always wins; on collision the requester that
//               did not win last time is granted.
// Ports       : valid_i[1:0]   request from channel 0 / channel 1
//               last_i         index of the most recently granted channel
//               grant_valid_o  some channel is granted
//               grant_idx_o    granted channel index (SRC_0 when no grant)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb_2
    import uart_pkg::*;
(
    input  logic [1:0] valid_i,
    input  uart_src_e  last_i,
    output logic       grant_valid_o,
    output uart_src_e  grant_idx_o
);

    always_comb begin
        grant_valid_o = |valid_i;
        grant_idx_o   = SRC_0;
        case (valid_i)
            2'b01:   grant_idx_o = SRC_0;
            2'b10:   grant_idx_o = SRC_1;
            // Collision: hand the grant to whoever did not win last time
            2'b11:   grant_idx_o = (last_i == SRC_0) ? SRC_1 : SRC_0;
            default: grant_idx_o = SRC_0;
        endcase
    end

endmodule : rr_arb_2
`default_nettype wire

// File: rtl/uart_tx_arb_2_a_1.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arb_2_a_1
// Description : Merges the CPU store byte stream (channel 0) and the DMA /
//               peripheral byte stream (channel 1) onto the single UART TX
//               path. Round-robin on collision, one-entry registered output
//               stage, each output byte tagged with its source channel.
// Ports       : clk_i, rst_ni                 clock, async active-low reset
//               in1_data_i/valid_i/ready_o    channel 0 handshake
//               in2_data_i/valid_i/ready_o    channel 1 handshake
//               out_data_o/src_o/valid_o      registered byte to TX shifter
//               out_ready_i                   TX shifter takes the byte
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arb_2_a_1
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] in1_data_i,
    input  logic              in1_valid_i,
    output logic              in1_ready_o,
    input  logic [DATA_W-1:0] in2_data_i,
    input  logic              in2_valid_i,
    output logic              in2_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_src_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);

    localparam logic [0:0] S_EMPTY = ST_EMPTY;
    localparam logic [0:0] S_FULL  = ST_FULL;

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] data_q,  data_d;
    uart_src_e         src_q,   src_d;
    uart_src_e         last_q,  last_d;

    logic              grant_valid;
    uart_src_e         grant_idx;
    logic              can_load;
    logic              accept;

    rr_arb_2 u_arb (
        .valid_i       ({in2_valid_i, in1_valid_i}),
        .last_i        (last_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    // Register can take a new byte when empty, or when the current byte
    // leaves in this same cycle.
    assign can_load = (state_q == S_EMPTY) | out_ready_i;
    assign accept   = can_load & grant_valid;

    assign in1_ready_o = accept & (grant_idx == SRC_0);
    assign in2_ready_o = accept & (grant_idx == SRC_1);

    assign out_valid_o = (state_q == S_FULL);
    assign out_data_o  = data_q;
    assign out_src_o   = src_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        src_d   = src_q;
        last_d  = last_q;
        if (accept) begin
            state_d = S_FULL;
            data_d  = (grant_idx == SRC_1) ? in2_data_i : in1_data_i;
            src_d   = grant_idx;
            last_d  = grant_idx;
        end else if ((state_q == S_FULL) && out_ready_i) begin
            state_d = S_EMPTY;
        end
    end

    // last_q resets to channel 1 so channel 0 wins the first collision
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_EMPTY;
            data_q  <= '0;
            src_q   <= SRC_0;
            last_q  <= SRC_1;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            last_q  <= last_d;
        end
    end

endmodule : uart_tx_arb_2_a_1
`default_nettype wire

// File: tb/tb_uart_tx_arb_2_a_1.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arb_2_a_1
// Description : Self-checking bench for uart_tx_arb_2_a_1. A transaction-level
//               model (one-entry holding slot plus per-channel byte queues)
//               is compared against the DUT every cycle, alongside directed
//               literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arb_2_a_1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in1_data, in2_data;
    logic       in1_valid, in2_valid;
    logic       in1_ready, in2_ready;
    logic [7:0] out_data;
    logic       out_src, out_valid, out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_arb_2_a_1 #(.DATA_W(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in1_data_i  (in1_data),
        .in1_valid_i (in1_valid),
        .in1_ready_o (in1_ready),
        .in2_data_i  (in2_data),
        .in2_valid_i (in2_valid),
        .in2_ready_o (in2_ready),
        .out_data_o  (out_data),
        .out_src_o   (out_src),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Winner among offered channels: lone requester wins, collision goes to
    // the channel that did not win last time. -1 means nobody offers.
    function automatic int pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return (last == 1'b0) ? 1 : 0;
        if (v0)       return 0;
        if (v1)       return 1;
        return -1;
    endfunction

    // ---------------- behavioural model ----------------
    logic       m_valid, m_src, m_last;
    logic [7:0] m_data;
    logic       m_acc1, m_acc2;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         starve[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_data = 8'h00; m_src = 1'b0; m_last = 1'b1;
            m_acc1 = 1'b0; m_acc2 = 1'b0;
            q0.delete(); q1.delete();
            starve[0] = 0; starve[1] = 0;
        end else begin
            int  p;
            bit  room;
            p    = pick(in1_valid, in2_valid, m_last);
            room = !m_valid || out_ready;
            m_acc1 = 1'b0; m_acc2 = 1'b0;
            if (!in1_valid) starve[0] = 0;
            if (!in2_valid) starve[1] = 0;
            if (room && p >= 0) begin
                m_valid = 1'b1;
                m_src   = (p == 1);
                m_last  = (p == 1);
                m_data  = (p == 1) ? in2_data : in1_data;
                if (p == 1) begin q1.push_back(in2_data); m_acc2 = 1'b1; end
                else        begin q0.push_back(in1_data); m_acc1 = 1'b1; end
                if (in1_valid && in2_valid) begin
                    starve[1-p]++;
                    chk("no_starve", 32'(starve[1-p] <= 1), 32'd1);
                end
                starve[p] = 0;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_data",  32'(out_data),  32'd0);
            chk("rst_out_src",   32'(out_src),   32'd0);
        end else begin
            int p;
            bit room;
            p    = pick(in1_valid, in2_valid, m_last);
            room = !m_valid || out_ready;
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("out_data", 32'(out_data), 32'(m_data));
                chk("out_src",  32'(out_src),  32'(m_src));
            end
            chk("in1_ready", 32'(in1_ready), 32'(room && p == 0));
            chk("in2_ready", 32'(in2_ready), 32'(room && p == 1));
            if (out_valid && out_ready) begin
                if (out_src == 1'b0) begin
                    chk("sb_q0_nonempty", 32'(q0.size() > 0), 32'd1);
                    if (q0.size() > 0) chk("sb_q0_order", 32'(out_data), 32'(q0.pop_front()));
                end else begin
                    chk("sb_q1_nonempty", 32'(q1.size() > 0), 32'd1);
                    if (q1.size() > 0) chk("sb_q1_order", 32'(out_data), 32'(q1.pop_front()));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        in1_valid = 1'b0; in2_valid = 1'b0;
        in1_data  = 8'h00; in2_data  = 8'h00;
    endtask

    // Leaves the bench at posedge+1 with reset released
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle_inputs();
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [7:0] coll_exp [4];

    initial begin
        rst_n = 1'b0; out_ready = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_data",  32'(out_data),  32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Channel 0 alone
        in1_valid = 1'b1; in1_data = 8'h41; out_ready = 1'b1;
        @(negedge clk);
        chk("t1_in1_ready", 32'(in1_ready), 32'd1);
        chk("t1_in2_ready", 32'(in2_ready), 32'd0);
        @(posedge clk); #1 in1_valid = 1'b0;
        @(negedge clk);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data",  32'(out_data),  32'h41);
        chk("t1_src",   32'(out_src),   32'd0);

        // Collision right after reset: strict alternation starting with 0
        do_reset();
        coll_exp[0] = 8'h10; coll_exp[1] = 8'h20; coll_exp[2] = 8'h10; coll_exp[3] = 8'h20;
        in1_valid = 1'b1; in1_data = 8'h10;
        in2_valid = 1'b1; in2_data = 8'h20;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t2_valid", 32'(out_valid), 32'd1);
            chk("t2_data",  32'(out_data),  32'(coll_exp[k]));
            chk("t2_src",   32'(out_src),   32'(k % 2));
        end
        @(posedge clk); #1 idle_inputs();

        // Backpressure
        do_reset();
        in1_valid = 1'b1; in1_data = 8'h55; out_ready = 1'b0;
        @(posedge clk); #1 in1_data = 8'h66;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_hold_data", 32'(out_data),  32'h55);
            chk("t3_in1_ready", 32'(in1_ready), 32'd0);
            chk("t3_in2_ready", 32'(in2_ready), 32'd0);
            @(posedge clk);
        end
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("t3_drain_accept", 32'(in1_ready), 32'd1);
        chk("t3_drain_data",   32'(out_data),  32'h55);
        @(posedge clk); #1 in1_valid = 1'b0;
        @(negedge clk);
        chk("t3_next_valid", 32'(out_valid), 32'd1);
        chk("t3_next_data",  32'(out_data),  32'h66);

        // Channel 1 streaming, then a collision goes to channel 0
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in2_valid = 1'b1; in2_data = 8'(i);
            @(negedge clk);
            chk("t4_in2_ready", 32'(in2_ready), 32'd1);
            if (i > 1) begin
                chk("t4_stream_data", 32'(out_data), 32'(i - 1));
                chk("t4_stream_src",  32'(out_src),  32'd1);
            end
            @(posedge clk); #1;
        end
        in1_valid = 1'b1; in1_data = 8'hA0;
        in2_valid = 1'b1; in2_data = 8'hB0;
        @(negedge clk);
        chk("t4_last_byte", 32'(out_data),  32'h08);
        chk("t4_coll_in1",  32'(in1_ready), 32'd1);
        @(posedge clk); #1 idle_inputs();
        @(negedge clk);
        chk("t4_coll_data", 32'(out_data), 32'hA0);
        chk("t4_coll_src",  32'(out_src),  32'd0);

        // Reset while holding a byte
        @(posedge clk); #1;
        out_ready = 1'b0; in1_valid = 1'b1; in1_data = 8'h7E;
        @(posedge clk); #1 in1_valid = 1'b0;
        @(negedge clk);
        chk("t5_full_data", 32'(out_data), 32'h7E);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 32'(out_valid), 32'd0);
        chk("t5_async_data",  32'(out_data),  32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; out_ready = 1'b1;
        in1_valid = 1'b1; in1_data = 8'h11;
        in2_valid = 1'b1; in2_data = 8'h22;
        @(negedge clk);
        chk("t5_prio_in1", 32'(in1_ready), 32'd1);
        @(posedge clk); #1 idle_inputs();
        @(negedge clk);
        chk("t5_prio_data", 32'(out_data), 32'h11);

        // Random traffic obeying the hold-while-not-ready rule
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (!(in1_valid && !m_acc1)) begin
                in1_valid = ($urandom_range(0, 2) != 0);
                in1_data  = 8'($urandom);
            end
            if (!(in2_valid && !m_acc2)) begin
                in2_valid = ($urandom_range(0, 2) != 0);
                in2_data  = 8'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        // Let any pending offers go through, then drain
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (in1_valid && m_acc1) in1_valid = 1'b0;
            if (in2_valid && m_acc2) in2_valid = 1'b0;
            @(posedge clk); #1;
        end
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("sb_q0_drained", 32'(q0.size()), 32'd0);
        chk("sb_q1_drained", 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_tx_arb_2_a_1
`default_nettype wire
